// File: rtl/duck_pkg.sv
// duck_pkg: shared duck sprite types, geometry and frame-number constants
package duck_pkg;
  typedef enum logic [1:0] {HIDDEN, FLYING, SHOT, FALLING} duck_state_t;
  localparam int SPRITE_W = 47;
  localparam int SPRITE_H = 47;
  localparam int FLY_FRAMES = 3;
  localparam int FRAME_DIV = 8;
  localparam int SHOT_HOLD = 30;
  localparam int TRANSPARENT_IDX = 1;
  localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
  localparam int SHOT_FRAME = FLY_FRAMES;
  localparam int FALL_FRAME = FLY_FRAMES + 1;
  localparam int ADDR_W = $clog2((FLY_FRAMES + 2) * FRAME_SZ);
endpackage

// File: rtl/duck_anim_fsm.sv
// duck_anim_fsm: duck state sequencing (clk, rst, frame_tick, hit, spawn, fall_done in; state, frame out)
module duck_anim_fsm
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        spawn,
  input  logic        fall_done,
  output duck_state_t state,
  output logic [2:0]  frame
);
  logic [4:0] cnt;
  logic [1:0] anim;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HIDDEN;
      cnt <= '0;
      anim <= '0;
    end else if (spawn) begin
      state <= FLYING;
      cnt <= '0;
      anim <= '0;
    end else if (hit && state == FLYING) begin
      state <= SHOT;
      cnt <= '0;
    end else if (frame_tick) begin
      case (state)
        FLYING: begin
          cnt <= cnt == 5'(FRAME_DIV - 1) ? 5'd0 : cnt + 5'd1;
          if (cnt == 5'(FRAME_DIV - 1)) anim <= anim == 2'(FLY_FRAMES - 1) ? 2'd0 : anim + 2'd1;
        end
        SHOT: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(SHOT_HOLD - 1)) begin
            state <= FALLING;
            cnt <= '0;
          end
        end
        FALLING: if (fall_done) state <= HIDDEN;
        default: ;
      endcase
    end
  end
  assign frame = state == FLYING ? {1'b0, anim} :
                 state == SHOT ? 3'(SHOT_FRAME) :
                 state == FALLING ? 3'(FALL_FRAME) : 3'd0;
endmodule

// File: rtl/duck_sprite_fetch.sv
// duck_sprite_fetch: duck box test and sprite-ROM addressing (Clk, Reset, frame_tick, DrawX/Y, duck_x/y, face_left, hit, spawn, fall_done, rom_q in; rom_addr, palette_index, duck_on, state_o out)
module duck_sprite_fetch
  import duck_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        duck_x,
  input  logic [9:0]        duck_y,
  input  logic              face_left,
  input  logic              hit,
  input  logic              spawn,
  input  logic              fall_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        palette_index,
  output logic              duck_on,
  output logic [1:0]        state_o
);
  duck_state_t state;
  logic [2:0] frame;
  logic [9:0] px, py;
  logic face, inb, in_q, in_d;
  logic [10:0] ox, oy;
  logic [5:0] col;
  duck_anim_fsm u_fsm (
    .clk(Clk),
    .rst(Reset),
    .frame_tick(frame_tick),
    .hit(hit),
    .spawn(spawn),
    .fall_done(fall_done),
    .state(state),
    .frame(frame)
  );
  // 11-bit unsigned offsets: left/above the box wraps high and fails the compare
  assign ox = {1'b0, DrawX} - {1'b0, px};
  assign oy = {1'b0, DrawY} - {1'b0, py};
  assign inb = ox < 11'(SPRITE_W) && oy < 11'(SPRITE_H);
  assign col = face ? 6'(SPRITE_W - 1) - ox[5:0] : ox[5:0];
  always_ff @(posedge Clk) begin
    if (Reset) begin
      px <= '0;
      py <= '0;
      face <= 1'b0;
      rom_addr <= '0;
      in_q <= 1'b0;
      in_d <= 1'b0;
    end else begin
      if (frame_tick) begin
        px <= duck_x;
        py <= duck_y;
        face <= face_left;
      end
      rom_addr <= inb ? ADDR_W'(int'(frame) * FRAME_SZ + int'(oy[5:0]) * SPRITE_W + int'(col)) : '0;
      in_q <= inb;
      in_d <= in_q;
    end
  end
  // rom_q is already the ROM's output register, so gating it here keeps the 2-cycle latency
  assign palette_index = in_d ? rom_q : 4'd0;
  assign duck_on = in_d && rom_q != 4'(TRANSPARENT_IDX) && state != HIDDEN;
  assign state_o = state;
endmodule

// File: tb/tb_duck_sprite_fetch.sv
// tb_duck_sprite_fetch: self-checking bench for duck_sprite_fetch
module tb_duck_sprite_fetch;
  import duck_pkg::*;
  logic clk = 0, rst = 1, ft = 0, hit = 0, spawn = 0, fd = 0, fl = 0;
  logic [9:0] dx = 0, dy = 0, xq = 0, yq = 0;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0] rom_q = 0, pal;
  logic on;
  logic [1:0] st;
  int errs = 0, checks = 0;
  duck_state_t ms = HIDDEN;
  int fly_n = 0, shot_n = 0, mpx = 0, mpy = 0, prev_addr = 0;
  logic mface = 0, prev_in = 0;
  typedef struct {logic [9:0] x; logic [9:0] y; logic f; int addr; logic inb;} vec_t;
  vec_t vt[7];

  duck_sprite_fetch dut (
    .Clk(clk), .Reset(rst), .frame_tick(ft), .DrawX(dx), .DrawY(dy),
    .duck_x(xq), .duck_y(yq), .face_left(fl), .hit(hit), .spawn(spawn),
    .fall_done(fd), .rom_addr(rom_addr), .rom_q(rom_q), .palette_index(pal),
    .duck_on(on), .state_o(st)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom(int a);
    return 4'((a * 7 + 3) & 15);
  endfunction

  always @(posedge clk) rom_q <= rom(int'(rom_addr));

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic step();
    int fr, ox, oy, addr, rq;
    logic inb;
    fr = ms == FLYING ? (fly_n / FRAME_DIV) % FLY_FRAMES :
         ms == SHOT ? FLY_FRAMES : ms == FALLING ? FLY_FRAMES + 1 : 0;
    ox = int'(dx) - mpx;
    oy = int'(dy) - mpy;
    inb = ox >= 0 && ox < SPRITE_W && oy >= 0 && oy < SPRITE_H;
    addr = inb ? fr * SPRITE_W * SPRITE_H + oy * SPRITE_W + (mface ? SPRITE_W - 1 - ox : ox) : 0;
    rq = int'(rom(prev_addr));
    if (rst) begin
      ms = HIDDEN; fly_n = 0; shot_n = 0; mpx = 0; mpy = 0; mface = 0;
      addr = 0; inb = 0; prev_in = 0;
    end else begin
      if (spawn) begin
        ms = FLYING; fly_n = 0;
      end else if (hit && ms == FLYING) begin
        ms = SHOT; shot_n = 0;
      end else if (ft) begin
        if (ms == FLYING) fly_n++;
        else if (ms == SHOT) begin
          shot_n++;
          if (shot_n == SHOT_HOLD) ms = FALLING;
        end else if (ms == FALLING && fd) ms = HIDDEN;
      end
      if (ft) begin
        mpx = int'(xq); mpy = int'(yq); mface = fl;
      end
    end
    @(posedge clk);
    #1;
    chk("state", int'(st), int'(ms));
    chk("rom_addr", int'(rom_addr), addr);
    chk("duck_on", int'(on), int'(prev_in && rq != TRANSPARENT_IDX && ms != HIDDEN));
    chk("palette", int'(pal), prev_in ? rq : 0);
    prev_in = inb;
    prev_addr = addr;
  endtask

  task automatic tick();
    ft = 1; step(); ft = 0; step();
  endtask

  task automatic reset_spawn();
    rst = 1; step(); rst = 0;
    xq = 100; yq = 50; fl = 0; dx = 100; dy = 50;
    spawn = 1; ft = 1; step(); spawn = 0; ft = 0;
  endtask

  initial begin
    vt[0] = '{10'd100, 10'd50, 1'b0, 0, 1'b1};
    vt[1] = '{10'd147, 10'd50, 1'b0, 0, 1'b0};
    vt[2] = '{10'd146, 10'd96, 1'b0, 2208, 1'b1};
    vt[3] = '{10'd100, 10'd50, 1'b1, 46, 1'b1};
    vt[4] = '{10'd100, 10'd51, 1'b1, 93, 1'b1};
    vt[5] = '{10'd99, 10'd50, 1'b0, 0, 1'b0};
    vt[6] = '{10'd100, 10'd97, 1'b0, 0, 1'b0};
    step();
    chk("reset_state", int'(st), int'(HIDDEN));
    chk("reset_on", int'(on), 0);
    reset_spawn();
    foreach (vt[i]) begin
      fl = vt[i].f; ft = 1; step(); ft = 0;
      dx = vt[i].x; dy = vt[i].y; step();
      chk("vec_addr", int'(rom_addr), vt[i].addr);
      step();
      chk("vec_on", int'(on), int'(vt[i].inb && rom(vt[i].addr) != 4'(TRANSPARENT_IDX)));
    end
    reset_spawn();
    repeat (8) tick();
    chk("fly_state", int'(st), int'(FLYING));
    chk("frame1_addr", int'(rom_addr), 2209);
    repeat (16) tick();
    chk("wrap_addr", int'(rom_addr), 0);
    hit = 1; step(); hit = 0; step();
    chk("shot_state", int'(st), int'(SHOT));
    chk("shot_addr", int'(rom_addr), 6627);
    repeat (30) tick();
    chk("fall_state", int'(st), int'(FALLING));
    chk("fall_addr", int'(rom_addr), 8836);
    fd = 1; tick(); fd = 0; step();
    chk("hidden_state", int'(st), int'(HIDDEN));
    chk("hidden_on", int'(on), 0);
    spawn = 1; hit = 1; step(); spawn = 0; hit = 0;
    chk("spawn_wins", int'(st), int'(FLYING));
    rst = 1; step(); rst = 0;
    hit = 1; step(); hit = 0;
    chk("hit_hidden", int'(st), int'(HIDDEN));
    reset_spawn();
    step(); step();
    chk("on_before_rst", int'(on), 1);
    rst = 1; step(); rst = 0;
    chk("rst_on", int'(on), 0);
    chk("rst_state", int'(st), int'(HIDDEN));
    xq = 600; yq = 50; ft = 1; step(); ft = 0;
    spawn = 1; step(); spawn = 0;
    dx = 5; dy = 60; step(); step();
    chk("clip_on", int'(on), 0);
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 499) == 0;
      spawn = $urandom_range(0, 149) == 0;
      hit = $urandom_range(0, 39) == 0;
      ft = $urandom_range(0, 9) == 0;
      fd = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 79) == 0) begin
        xq = 10'($urandom_range(0, 639));
        yq = 10'($urandom_range(0, 479));
        fl = 1'($urandom_range(0, 1));
      end
      dx = 10'(mpx + int'($urandom_range(0, 60)) - 6);
      dy = 10'(mpy + int'($urandom_range(0, 60)) - 6);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
